// File: rtl/cgp_fitness_eval.sv
// Fitness harness for a CGP LUT grid: sweeps every input vector into the grid,
// samples the outputs after a settle delay and counts bits matching a target truth table.
module cgp_fitness_eval #(
  parameter int N_IN          = 4,
  parameter int N_OUT         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int SCORE_W       = $clog2(N_OUT * (2 ** N_IN) + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [N_OUT*(2**N_IN)-1:0] target_tt,
  output logic [N_IN-1:0]            cgp_in,
  input  logic [N_OUT-1:0]           cgp_out,
  output logic                       busy,
  output logic                       done,
  output logic [SCORE_W-1:0]         fitness,
  output logic                       perfect
);

  localparam int V         = 2 ** N_IN;
  localparam int MAX_SCORE = N_OUT * V;
  localparam logic [N_IN-1:0] VEC_LAST    = '1;
  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_t;

  state_t               state;
  logic [N_OUT*V-1:0]   tt_q;
  logic [N_IN-1:0]      vec;
  logic [7:0]           settle;
  logic [SCORE_W-1:0]   acc;
  logic [SCORE_W-1:0]   match;
  logic [SCORE_W-1:0]   acc_next;
  logic [N_OUT-1:0]     diff;

  // Matching bits for the current vector: N_OUT minus the number of differing bits.
  always_comb begin
    diff  = cgp_out ^ tt_q[vec*N_OUT +: N_OUT];
    match = SCORE_W'(N_OUT);
    for (int unsigned j = 0; j < N_OUT; j++) begin
      if (diff[j]) match = match - SCORE_W'(1);
    end
    acc_next = acc + match;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tt_q    <= '0;
      vec     <= '0;
      settle  <= '0;
      acc     <= '0;
      cgp_in  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fitness <= '0;
      perfect <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tt_q   <= target_tt;
            vec    <= '0;
            settle <= '0;
            acc    <= '0;
            cgp_in <= '0;
            busy   <= 1'b1;
            state  <= EVAL;
          end
        end
        EVAL: begin
          if (abort) begin
            busy   <= 1'b0;
            cgp_in <= '0;
            state  <= IDLE;
          end else if (settle == SETTLE_LAST) begin
            // Final sample registers the result directly so the DONE cycle presents
            // fitness/done/busy=0 without an extra accumulate-then-copy step.
            if (vec == VEC_LAST) begin
              fitness <= acc_next;
              perfect <= (acc_next == SCORE_W'(MAX_SCORE));
              done    <= 1'b1;
              busy    <= 1'b0;
              cgp_in  <= '0;
              state   <= DONE;
            end else begin
              acc    <= acc_next;
              vec    <= vec + N_IN'(1);
              cgp_in <= vec + N_IN'(1);
              settle <= '0;
            end
          end else begin
            settle <= settle + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cgp_fitness_eval.sv
// Scoreboard bench for cgp_fitness_eval: directed evaluations against a behavioural grid,
// one DUT at default settle time and one with zero settle cycles.
module tb_cgp_fitness_eval;

  localparam logic [63:0] TT_ID   = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] TT_FLIP = 64'hFEDC_BA98_7654_3230;
  localparam logic [63:0] TT_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, start, abort, start0;
  logic [63:0] target_tt, target0;
  logic [3:0]  cgp_in, cgp_out, cgp_in0, cgp_out0;
  logic        busy, done, perfect, busy0, done0, perfect0;
  logic [6:0]  fitness, fitness0;
  logic        grid_zero;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int fit;
    int perf;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];
  exp_t e_m, e_m0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  assign cgp_out  = grid_zero ? 4'b0000 : cgp_in;
  assign cgp_out0 = cgp_in0;

  cgp_fitness_eval #(.N_IN(4), .N_OUT(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .target_tt(target_tt),
    .cgp_in(cgp_in), .cgp_out(cgp_out), .busy(busy), .done(done),
    .fitness(fitness), .perfect(perfect)
  );

  cgp_fitness_eval #(.N_IN(4), .N_OUT(4), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(1'b0), .target_tt(target0),
    .cgp_in(cgp_in0), .cgp_out(cgp_out0), .busy(busy0), .done(done0),
    .fitness(fitness0), .perfect(perfect0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e_m = q.pop_front();
          check("fitness", 32'(fitness), e_m.fit);
          check("perfect", 32'(perfect), e_m.perf);
          check("done_cycle", cyc, e_m.cyc);
        end
      end
      if (done0 === 1'b1) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done0: got done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e_m0 = q0.pop_front();
          check("fitness0", 32'(fitness0), e_m0.fit);
          check("perfect0", 32'(perfect0), e_m0.perf);
          check("done_cycle0", cyc, e_m0.cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && (q.size() > 0 || q0.size() > 0); i++) step(1);
    checks++;
    if (q.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, q.size() + q0.size());
      q.delete();
      q0.delete();
    end
  endtask

  task automatic push(input int fit, input int perf, input int c);
    exp_t e;
    e.fit = fit; e.perf = perf; e.cyc = c;
    q.push_back(e);
  endtask

  initial begin
    int t;
    exp_t e;
    rst = 1'b1; start = 1'b0; abort = 1'b0; start0 = 1'b0;
    target_tt = '0; target0 = '0; grid_zero = 1'b0;
    step(3);
    check("rst_cgp_in", 32'(cgp_in), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_fitness", 32'(fitness), 0);
    check("rst_perfect", 32'(perfect), 0);
    rst = 1'b0;
    step(2);

    // Identity grid, identity target: perfect score, done 49 cycles after start.
    target_tt = TT_ID; start = 1'b1; t = cyc;
    push(64, 1, t + 49);
    step(1);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    drain("identity");

    // Constant-zero grid against all-ones target; each vector held 3 cycles.
    grid_zero = 1'b1; target_tt = TT_ONES; start = 1'b1; t = cyc;
    push(0, 0, t + 49);
    step(1);
    start = 1'b0;
    begin
      int bad = 0;
      for (int k = 0; k < 48; k++) begin
        if (cgp_in !== 4'(k / 3)) bad++;
        step(1);
      end
      check("cgp_in_sweep_errs", bad, 0);
    end
    check("cgp_in_done", 32'(cgp_in), 0);
    check("busy_done", 32'(busy), 0);
    drain("zero_grid");
    grid_zero = 1'b0;

    // One target bit wrong; both settle configurations in parallel.
    target_tt = TT_FLIP; target0 = TT_FLIP; start = 1'b1; start0 = 1'b1; t = cyc;
    push(63, 0, t + 49);
    e.fit = 63; e.perf = 0; e.cyc = t + 17;
    q0.push_back(e);
    step(1);
    start = 1'b0; start0 = 1'b0;
    drain("flip");

    // start held: back-to-back runs; target change mid-run affects only the second.
    target_tt = TT_ID; start = 1'b1; t = cyc;
    push(64, 1, t + 49);
    push(63, 0, t + 99);
    step(10);
    target_tt = TT_FLIP;
    step(50);
    start = 1'b0;
    drain("held_start");

    // Abort in the vector-5 slot: no done, previous fitness retained.
    target_tt = TT_ID; start = 1'b1; t = cyc;
    step(1);
    start = 1'b0;
    step(15);
    check("cgp_in_before_abort", 32'(cgp_in), 5);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_cgp_in", 32'(cgp_in), 0);
    check("abort_fitness", 32'(fitness), 63);
    check("abort_perfect", 32'(perfect), 0);
    step(60);

    // Asynchronous reset mid-run clears outputs before the next edge.
    target_tt = TT_ID; start = 1'b1; t = cyc;
    step(1);
    start = 1'b0;
    step(19);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_cgp_in", 32'(cgp_in), 0);
    check("arst_fitness", 32'(fitness), 0);
    check("arst_perfect", 32'(perfect), 0);
    check("arst_done", 32'(done), 0);
    step(2);
    rst = 1'b0;
    step(80);
    check("post_rst_fitness", 32'(fitness), 0);
    check("post_rst_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
